// File: rtl/max_unpool_multi_pkg.sv
// Shared CNN pooling/unpooling definitions: argmax index encoding, map offset
// helpers and the unpool FSM state type.
package max_unpool_multi_pkg;

  localparam logic [1:0] IDX_TL = 2'd0;
  localparam logic [1:0] IDX_TR = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Element index of pooled element (d,i,j) in a ph x pw x D map.
  function automatic int unsigned pooled_elem(int unsigned d, int unsigned i, int unsigned j,
                                              int unsigned ph, int unsigned pw);
    return (d * ph + i) * pw + j;
  endfunction

  // Element index of unpooled element (d,r,c) in an h x w x D map.
  function automatic int unsigned unpooled_elem(int unsigned d, int unsigned r, int unsigned c,
                                                int unsigned h, int unsigned w);
    return (d * h + r) * w + c;
  endfunction

  // Argmax code that selects full-resolution position (r,c) within its 2x2 window.
  function automatic logic [1:0] window_idx(int unsigned r, int unsigned c);
    if ((r % 2) == 0) return ((c % 2) == 0) ? IDX_TL : IDX_TR;
    else              return ((c % 2) == 0) ? IDX_BL : IDX_BR;
  endfunction

  function automatic int unsigned ch_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/max_unpool_multi_if.sv
// Start/busy/done handshake and feature-map buses of the multi-channel unpool block.
interface max_unpool_multi_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 6,
  parameter int unsigned H          = 28,
  parameter int unsigned W          = 28
);
  localparam int unsigned IN_BITS  = (H / 2) * (W / 2) * D * DATA_WIDTH;
  localparam int unsigned IDX_BITS = (H / 2) * (W / 2) * D * 2;
  localparam int unsigned OUT_BITS = H * W * D * DATA_WIDTH;

  logic                start;
  logic [IN_BITS-1:0]  upIn;
  logic [IDX_BITS-1:0] upIdx;
  logic [OUT_BITS-1:0] upOut;
  logic                busy;
  logic                done;

  modport master (output start, upIn, upIdx, input upOut, busy, done);
  modport slave  (input start, upIn, upIdx, output upOut, busy, done);
endinterface

// File: rtl/max_unpool_single.sv
// Combinational 2x2 max-unpool of one channel: each pooled value goes to its
// argmax position, the other three window positions are zero.
module max_unpool_single
  import max_unpool_multi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned InputH     = 14,
  parameter int unsigned InputW     = 14
) (
  input  logic [InputH*InputW*DATA_WIDTH-1:0]   in_map,
  input  logic [InputH*InputW*2-1:0]            in_idx,
  output logic [4*InputH*InputW*DATA_WIDTH-1:0] out_c
);

  localparam int unsigned OutH = 2 * InputH;
  localparam int unsigned OutW = 2 * InputW;

  // One mux per output element, keyed on the argmax of the window it belongs to.
  for (genvar r = 0; r < OutH; r++) begin : g_row
    for (genvar c = 0; c < OutW; c++) begin : g_col
      localparam int unsigned PE  = pooled_elem(0, r / 2, c / 2, InputH, InputW);
      localparam int unsigned OE  = unpooled_elem(0, r, c, OutH, OutW);
      localparam logic [1:0]  SEL = window_idx(r, c);

      assign out_c[OE*DATA_WIDTH +: DATA_WIDTH] =
        (in_idx[PE*2 +: 2] == SEL) ? in_map[PE*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

endmodule

// File: rtl/max_unpool_multi.sv
// Channel-serial 2x2 max-unpool: one channel slice of upOut is written per
// clock under a start/busy/done handshake.
module max_unpool_multi
  import max_unpool_multi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 6,
  parameter int unsigned H          = 28,
  parameter int unsigned W          = 28
) (
  input logic               clk,
  input logic               reset,
  max_unpool_multi_if.slave bus
);

  localparam int unsigned PH        = H / 2;
  localparam int unsigned PW        = W / 2;
  localparam int unsigned IN_SLICE  = PH * PW * DATA_WIDTH;
  localparam int unsigned IDX_SLICE = PH * PW * 2;
  localparam int unsigned OUT_SLICE = H * W * DATA_WIDTH;
  localparam int unsigned OUT_BITS  = OUT_SLICE * D;
  localparam int unsigned CH_W      = ch_width(D);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(D - 1);

  if (((H % 2) != 0) || ((W % 2) != 0)) begin : g_odd_dims
    $error("max_unpool_multi: H and W must both be even");
  end

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                wr_en_c;
  logic                busy_d, done_d;
  logic                busy_q, done_q;
  int unsigned         ch_idx_c;
  logic [IN_SLICE-1:0]  in_slice_c;
  logic [IDX_SLICE-1:0] idx_slice_c;
  logic [OUT_SLICE-1:0] slice_out_c;
  logic [OUT_BITS-1:0]  up_out_q;

  // Select the current channel's pooled values and argmax codes.
  always_comb begin
    ch_idx_c    = 32'(ch_q);
    in_slice_c  = bus.upIn[IN_SLICE*ch_idx_c +: IN_SLICE];
    idx_slice_c = bus.upIdx[IDX_SLICE*ch_idx_c +: IDX_SLICE];
  end

  max_unpool_single #(
    .DATA_WIDTH (DATA_WIDTH),
    .InputH     (PH),
    .InputW     (PW)
  ) u_single (
    .in_map (in_slice_c),
    .in_idx (idx_slice_c),
    .out_c  (slice_out_c)
  );

  // Next-state, channel counter and write enable.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wr_en_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          ch_d    = '0;
        end
      end
      ST_RUN: begin
        wr_en_c = 1'b1;
        if (ch_q == CH_LAST) begin
          state_d = ST_DONE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Only the active channel's slice is overwritten; others hold their last run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_out_q <= '0;
    end else if (wr_en_c) begin
      up_out_q[OUT_SLICE*ch_idx_c +: OUT_SLICE] <= slice_out_c;
    end
  end

  assign bus.upOut = up_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_max_unpool_multi.sv
// Self-checking bench for max_unpool_multi (H=W=4, D=2): table of directed and
// random vectors against a scatter reference model, plus handshake/reset sequences.
module tb_max_unpool_multi;

  localparam int unsigned DW       = 16;
  localparam int unsigned D        = 2;
  localparam int unsigned H        = 4;
  localparam int unsigned W        = 4;
  localparam int unsigned PH       = H / 2;
  localparam int unsigned PW       = W / 2;
  localparam int unsigned IN_BITS  = PH * PW * D * DW;
  localparam int unsigned IDX_BITS = PH * PW * D * 2;
  localparam int unsigned OUT_BITS = H * W * D * DW;
  localparam int unsigned SLICE    = H * W * DW;
  localparam int unsigned NVEC     = 10;

  typedef logic [IN_BITS-1:0]  in_t;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [OUT_BITS-1:0] out_t;

  typedef struct {
    in_t  up_in;
    idx_t up_idx;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  out_t prev;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  max_unpool_multi_if #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) bus ();

  max_unpool_multi #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic in_t set_in(in_t v, int d, int i, int j, logic [DW-1:0] x);
    in_t r = v;
    r[((d * PH + i) * PW + j) * DW +: DW] = x;
    return r;
  endfunction

  function automatic idx_t set_idx(idx_t v, int d, int i, int j, logic [1:0] k);
    idx_t r = v;
    r[((d * PH + i) * PW + j) * 2 +: 2] = k;
    return r;
  endfunction

  function automatic out_t set_out(out_t v, int d, int r, int c, logic [DW-1:0] x);
    out_t o = v;
    o[((d * H + r) * W + c) * DW +: DW] = x;
    return o;
  endfunction

  // Reference: scatter each pooled value to row 2i+k/2, column 2j+k%2.
  function automatic out_t ref_unpool(in_t in_v, idx_t idx_v);
    out_t o = '0;
    for (int d = 0; d < D; d++)
      for (int i = 0; i < PH; i++)
        for (int j = 0; j < PW; j++) begin
          int k = int'(idx_v[((d * PH + i) * PW + j) * 2 +: 2]);
          o = set_out(o, d, 2 * i + k / 2, 2 * j + k % 2,
                      in_v[((d * PH + i) * PW + j) * DW +: DW]);
        end
    return o;
  endfunction

  // Map after channels 0..upto of a run have been written over the old map.
  function automatic out_t merge(out_t nw, out_t old, int upto);
    out_t r = old;
    for (int s = 0; s <= upto; s++) r[s * SLICE +: SLICE] = nw[s * SLICE +: SLICE];
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int w = 0; w < int'(IN_BITS / 32); w++) v.up_in[w * 32 +: 32] = $urandom();
    v.up_idx = IDX_BITS'($urandom());
    v.exp    = ref_unpool(v.up_in, v.up_idx);
    return v;
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full run from IDLE, checking each channel write and the busy/done timing.
  task automatic run_vec(vec_t v, string name);
    bus.upIn  = v.up_in;
    bus.upIdx = v.up_idx;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("%s busy@start", name), out_t'(bus.busy), out_t'(1));
    check($sformatf("%s done@start", name), out_t'(bus.done), out_t'(0));
    for (int k = 0; k < int'(D); k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s map ch%0d", name, k), bus.upOut, merge(v.exp, prev, k));
      check($sformatf("%s busy ch%0d", name, k), out_t'(bus.busy), out_t'(k < int'(D) - 1));
      check($sformatf("%s done ch%0d", name, k), out_t'(bus.done), out_t'(k == int'(D) - 1));
    end
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s done end", name), out_t'(bus.done), out_t'(0));
    check($sformatf("%s busy end", name), out_t'(bus.busy), out_t'(0));
    prev = v.exp;
  endtask

  initial begin
    vec_t v, va, vb;
    int   dn, bz, first, second;

    // Directed: all idx 0, ch0 1..4, ch1 0x11..0x14 -> top-left corners.
    v.up_in = '0; v.up_idx = '0; v.exp = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        v.up_in = set_in(v.up_in, 0, i, j, DW'(16'h0001 + 2 * i + j));
        v.up_in = set_in(v.up_in, 1, i, j, DW'(16'h0011 + 2 * i + j));
      end
    v.exp = set_out(v.exp, 0, 0, 0, 16'h0001);
    v.exp = set_out(v.exp, 0, 0, 2, 16'h0002);
    v.exp = set_out(v.exp, 0, 2, 0, 16'h0003);
    v.exp = set_out(v.exp, 0, 2, 2, 16'h0004);
    v.exp = set_out(v.exp, 1, 0, 0, 16'h0011);
    v.exp = set_out(v.exp, 1, 0, 2, 16'h0012);
    v.exp = set_out(v.exp, 1, 2, 0, 16'h0013);
    v.exp = set_out(v.exp, 1, 2, 2, 16'h0014);
    vecs[0] = v;

    // Index sweep on ch0 window (0,0), negative value: idx 3, 1, 2.
    v.up_in = set_in('0, 0, 0, 0, 16'h8000);
    v.up_idx = set_idx('0, 0, 0, 0, 2'd3);
    v.exp = set_out('0, 0, 1, 1, 16'h8000);
    vecs[1] = v;
    v.up_idx = set_idx('0, 0, 0, 0, 2'd1);
    v.exp = set_out('0, 0, 0, 1, 16'h8000);
    vecs[2] = v;
    v.up_idx = set_idx('0, 0, 0, 0, 2'd2);
    v.exp = set_out('0, 0, 1, 0, 16'h8000);
    vecs[3] = v;
    for (int n = 4; n < int'(NVEC); n++) vecs[n] = rand_vec();

    // Reset, asserted mid-cycle.
    bus.start = 1'b0; bus.upIn = '0; bus.upIdx = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset upOut", bus.upOut, '0);
    check("reset busy", out_t'(bus.busy), out_t'(0));
    check("reset done", out_t'(bus.done), out_t'(0));
    prev = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < int'(NVEC); n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // start pulsed in RUN and in DONE must be ignored.
    v = rand_vec();
    bus.upIn = v.up_in; bus.upIdx = v.up_idx; bus.start = 1'b1;
    dn = 0; bz = 0;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      dn += int'(bus.done);
      bz += int'(bus.busy);
      if (n == 0) bus.start = 1'b0;
      if (n == 1) bus.start = 1'b1;
      if (n == 3) bus.start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    check("ignore-start done pulses", out_t'(dn), out_t'(1));
    check("ignore-start busy cycles", out_t'(bz), out_t'(D));
    check("ignore-start map", bus.upOut, v.exp);
    prev = v.exp;

    // Reset after ch0 write, start held high during reset.
    v = rand_vec();
    bus.upIn = v.up_in; bus.upIdx = v.up_idx; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort ch0 written", bus.upOut, merge(v.exp, prev, 0));
    #2 reset = 1'b1;
    bus.start = 1'b1;
    #1;
    check("abort upOut", bus.upOut, '0);
    check("abort busy", out_t'(bus.busy), out_t'(0));
    check("abort done", out_t'(bus.done), out_t'(0));
    @(posedge clk);
    @(negedge clk);
    check("start under reset busy", out_t'(bus.busy), out_t'(0));
    reset = 1'b0;
    bus.start = 1'b0;
    dn = 0; bz = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      dn += int'(bus.done);
      bz += int'(bus.busy);
    end
    check("abort no done", out_t'(dn), out_t'(0));
    check("abort idle busy", out_t'(bz), out_t'(0));
    check("abort map stays zero", bus.upOut, '0);
    prev = '0;
    run_vec(rand_vec(), "post-abort");

    // start held high across two runs with different inputs.
    va = rand_vec();
    vb = rand_vec();
    bus.upIn = va.up_in; bus.upIdx = va.up_idx; bus.start = 1'b1;
    first = -1; second = -1; dn = 0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (first < 0) begin
          first = n;
          check("b2b first map", bus.upOut, va.exp);
          bus.upIn = vb.up_in; bus.upIdx = vb.up_idx;
        end else if (second < 0) begin
          second = n;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b first done latency", out_t'(first), out_t'(D));
    check("b2b done spacing", out_t'(second - first), out_t'(D + 2));
    check("b2b done pulses", out_t'(dn), out_t'(2));
    check("b2b second map", bus.upOut, vb.exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
